// File: rtl/irq_ctrl_pkg.sv
// saratoga: shared rv32 CSR types, CSR addresses and interrupt-controller
// constants. Imported by the irq_ctrl slice (interface, encoder, top).
package saratoga;

  typedef logic [11:0] csr_addr_t;
  typedef logic [31:0] csr_data_t;

  localparam csr_addr_t csr_addr_mie      = 12'h304;
  localparam csr_addr_t csr_addr_mip      = 12'h344;
  localparam csr_addr_t csr_addr_mirqmode = 12'h7C0;

  // mcause code assigned to external channel 0
  localparam int unsigned IRQ_FIRST_CAUSE = 16;

  localparam int unsigned CAUSE_W = 5;
  typedef logic [CAUSE_W-1:0] cause_t;

endpackage

// File: rtl/irq_ctrl_if.sv
// irq_ctrl_if: CSR access bus between the core (master) and irq_ctrl (slave).
//   csr_rd_en / csr_wr_en : read / write strobes
//   csr_addr              : 12-bit CSR address
//   csr_wr_data           : write data
//   csr_rd_data           : combinational read data (slave output)
interface irq_ctrl_if;
  import saratoga::*;

  logic      csr_rd_en;
  logic      csr_wr_en;
  csr_addr_t csr_addr;
  csr_data_t csr_wr_data;
  csr_data_t csr_rd_data;

  modport master (
    output csr_rd_en, csr_wr_en, csr_addr, csr_wr_data,
    input  csr_rd_data
  );

  modport slave (
    input  csr_rd_en, csr_wr_en, csr_addr, csr_wr_data,
    output csr_rd_data
  );

endinterface

// File: rtl/irq_ctrl_prio_enc.sv
// irq_prio_enc: lowest-index-first priority encoder.
//   req   : request vector, WIDTH bits
//   valid : any request bit set
//   index : position of the lowest set request bit (0 when !valid)
module irq_prio_enc #(
  parameter  int unsigned WIDTH = 10,
  localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] req,
  output logic             valid,
  output logic [IDX_W-1:0] index
);

  always_comb begin
    valid = 1'b0;
    index = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (req[i] && !valid) begin
        valid = 1'b1;
        index = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl: external interrupt controller exposing mip/mie (bits
// FIRST_CAUSE..FIRST_CAUSE+NUM_IRQ-1) and custom mirqmode (0x7C0) CSRs.
// Each channel is edge (sticky pending) or level (pending tracks input).
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   irq_in      : raw interrupt lines
//   global_mie  : mstatus.MIE
//   csr         : CSR access bus (irq_ctrl_if.slave)
//   int_req     : interrupt request (combinational)
//   int_cause   : cause code of highest-priority request, 0 when idle
//   int_ack     : single-cycle trap-taken pulse
// Config macro IRQ_CTRL_SYNC_EN: adds a 2-flop synchronizer on irq_in.
module irq_ctrl
  import saratoga::*;
#(
  parameter int unsigned        NUM_IRQ      = 10,
  parameter int unsigned        FIRST_CAUSE  = IRQ_FIRST_CAUSE,
  parameter logic [NUM_IRQ-1:0] EDGE_DEFAULT = '1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               global_mie,
  irq_ctrl_if.slave          csr,
  output logic               int_req,
  output cause_t             int_cause,
  input  logic               int_ack
);

  localparam int unsigned IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  if (NUM_IRQ < 1 || NUM_IRQ > 16) begin : g_bad_num_irq
    $error("irq_ctrl: NUM_IRQ must be in 1..16");
  end
  if (FIRST_CAUSE + NUM_IRQ > 32) begin : g_bad_first_cause
    $error("irq_ctrl: FIRST_CAUSE + NUM_IRQ must not exceed 32");
  end

  logic [NUM_IRQ-1:0] synced;
  logic [NUM_IRQ-1:0] prev;
  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] pending_next;
  logic [NUM_IRQ-1:0] mie_en;
  logic [NUM_IRQ-1:0] irq_mode;
  logic [NUM_IRQ-1:0] mode_next;
  logic [NUM_IRQ-1:0] to_edge;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] clr;
  logic [NUM_IRQ-1:0] ack_vec;
  logic [NUM_IRQ-1:0] wr_field;
  logic               wr_mip;
  logic               wr_mie;
  logic               wr_mode;
  logic               enc_valid;
  logic [IDX_W-1:0]   enc_index;
  csr_data_t          rd_data;
  logic               unused_wr;

`ifdef IRQ_CTRL_SYNC_EN
  logic [NUM_IRQ-1:0] sync_q1;
  logic [NUM_IRQ-1:0] sync_q2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= irq_in;
      sync_q2 <= sync_q1;
    end
  end

  assign synced = sync_q2;
`else
  assign synced = irq_in;
`endif

  assign wr_mip    = csr.csr_wr_en && (csr.csr_addr == csr_addr_mip);
  assign wr_mie    = csr.csr_wr_en && (csr.csr_addr == csr_addr_mie);
  assign wr_mode   = csr.csr_wr_en && (csr.csr_addr == csr_addr_mirqmode);
  assign wr_field  = csr.csr_wr_data[FIRST_CAUSE +: NUM_IRQ];
  assign unused_wr = ^csr.csr_wr_data;

  assign mode_next = wr_mode ? csr.csr_wr_data[NUM_IRQ-1:0] : irq_mode;
  assign to_edge   = ~irq_mode & mode_next;
  assign rise      = synced & ~prev;

  irq_prio_enc #(.WIDTH(NUM_IRQ)) u_prio (
    .req   (pending & mie_en),
    .valid (enc_valid),
    .index (enc_index)
  );

  assign int_req   = global_mie & enc_valid;
  assign int_cause = int_req ? (cause_t'(FIRST_CAUSE) + cause_t'(enc_index)) : '0;

  always_comb begin
    ack_vec = '0;
    if (int_ack && int_req) ack_vec[enc_index] = 1'b1;
  end

  // Writing 0 to a mip bit clears it; writing 1 is ignored.
  assign clr = (wr_mip ? ~wr_field : '0) | ack_vec;

  // Edge: a new rise beats any same-cycle clear. Level: follow the synced
  // input, except on a level-to-edge switch, which starts from cleared.
  assign pending_next = (irq_mode & (rise | (pending & ~clr)))
                      | (~irq_mode & ~to_edge & synced);

  // prev samples synced every cycle, so a level-to-edge switch already
  // compares against the current level and sees no spurious edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending  <= '0;
      prev     <= '0;
      mie_en   <= '0;
      irq_mode <= EDGE_DEFAULT;
    end else begin
      pending  <= pending_next;
      prev     <= synced;
      irq_mode <= mode_next;
      if (wr_mie) mie_en <= wr_field;
    end
  end

  always_comb begin
    rd_data = '0;
    if (csr.csr_rd_en && rst_n) begin
      case (csr.csr_addr)
        csr_addr_mip:      rd_data[FIRST_CAUSE +: NUM_IRQ] = pending;
        csr_addr_mie:      rd_data[FIRST_CAUSE +: NUM_IRQ] = mie_en;
        csr_addr_mirqmode: rd_data[NUM_IRQ-1:0]            = irq_mode;
        default:           rd_data = '0;
      endcase
    end
  end

  assign csr.csr_rd_data = rd_data;

endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: scenario bench for irq_ctrl (NUM_IRQ=10, FIRST_CAUSE=16).
// Expected values are queued when stimulus is applied and popped when the
// corresponding DUT output is sampled.
module tb_irq_ctrl;
  import saratoga::*;

  localparam int unsigned N  = 10;
  localparam int unsigned FC = 16;
`ifdef IRQ_CTRL_SYNC_EN
  localparam int unsigned LAT = 3;
`else
  localparam int unsigned LAT = 1;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] irq_in = '0;
  logic         global_mie = 1'b0;
  logic         int_ack = 1'b0;
  logic         int_req;
  cause_t       int_cause;

  irq_ctrl_if bus ();

  irq_ctrl #(
    .NUM_IRQ      (N),
    .FIRST_CAUSE  (FC),
    .EDGE_DEFAULT (10'h3FF)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .irq_in     (irq_in),
    .global_mie (global_mie),
    .csr        (bus),
    .int_req    (int_req),
    .int_cause  (int_cause),
    .int_ack    (int_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic push(input string n, input logic [31:0] v);
    sb.push_back('{n, v});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_write(input csr_addr_t a, input csr_data_t d);
    bus.csr_wr_en   = 1'b1;
    bus.csr_addr    = a;
    bus.csr_wr_data = d;
    tick();
    bus.csr_wr_en   = 1'b0;
    bus.csr_addr    = '0;
    bus.csr_wr_data = '0;
  endtask

  task automatic csr_read(input csr_addr_t a, output csr_data_t d);
    bus.csr_rd_en = 1'b1;
    bus.csr_addr  = a;
    #1;
    d = bus.csr_rd_data;
    bus.csr_rd_en = 1'b0;
    bus.csr_addr  = '0;
  endtask

  task automatic test_reset();
    exp_t e;
    csr_data_t rd;
    rst_n = 1'b0;
    repeat (3) tick();
    push("rst_req", 32'd0);
    push("rst_cause", 32'd0);
    push("rst_rd_in_reset", 32'd0);
    e = sb.pop_front(); n_checks++;
    if (32'(int_req) !== e.exp) begin n_errors++; $display("FAIL %s: actual %0h required %0h", e.name, int_req, e.exp); end
    e = sb.pop_front(); n_checks++;
    if (32'(int_cause) !== e.exp) begin n_errors++; $display("FAIL %s: actual %0h required %0h", e.name, int_cause, e.exp); end
    csr_read(csr_addr_mirqmode, rd);
    e = sb.pop_front(); n_checks++;
    if (rd !== e.exp) begin n_errors++; $display("FAIL %s: actual %0h required %0h", e.name, rd, e.exp); end
    rst_n = 1'b1;
    tick();
    push("rst_mip", 32'h0);
    push("rst_mie", 32'h0);
    push("rst_mirqmode", 32'h3FF);
    push("rst_unmapped", 32'h0);
    csr_read(csr_addr_mip, rd);
    e = sb.pop_front(); n_checks++;
    if (rd !== e.exp) begin n_errors++; $display("FAIL %s: actual %0h required %0h", e.name, rd, e.exp); end
    csr_read(csr_addr_mie, rd);
    e = sb.pop_front(); n_checks++;
    if (rd !== e.exp) begin n_errors++; $display("FAIL %s: actual %0h required %0h", e.name, rd, e.exp); end
    csr_read(csr_addr_mirqmode, rd);
    e = sb.pop_front(); n_checks++;
    if (rd !== e.exp) begin n_errors++; $display("FAIL %s: actual %0h required %0h", e.name, rd, e.exp); end
    csr_read(12'h305, rd);
    e = sb.pop_front(); n_checks++;
    if (rd !== e.exp) begin n_errors++; $display("FAIL %s: actual %0h required %0h", e.name, rd, e.exp); end
  endtask

  task automatic test_edge();
    exp_t e;
    csr_write(csr_addr_mie, 32'h03FF_0000);
    global_mie = 1'b1;
    irq_in[2] = 1'b1;
    push("edge_early_req", 32'd0);
    push("edge_req", 32'd1);
    push("edge_cause", 32'd18);
    push("edge_hold_req", 32'd1);
    push("edge_ack_req", 32'd0);
    push("edge_ack_cause", 32'd0);
    for (int k = 0; k < int'(LAT); k++) begin
      if (k == int'(LAT) - 1) begin
        e = sb.pop_front(); n_checks++;
        if (32'(int_req) !== e.exp) begin n_errors++; $display("FAIL %s: actual %0h required %0h", e.name, int_req, e.exp); end
      end
      tick();
      if (k == 0) irq_in[2] = 1'b0;
    end
    e = sb.pop_front(); n_checks++;
    if (32'(int_req) !== e.exp) begin n_errors++; $display("FAIL %s: actual %0h required %0h", e.name, int_req, e.exp); end
    e = sb.pop_front(); n_checks++;
    if (32'(int_cause) !== e.exp) begin n_errors++; $display("FAIL %s: actual %0h required %0h", e.name, int_cause, e.exp); end
    repeat (4) tick();
    e = sb.pop_front(); n_checks++;
    if (32'(int_req) !== e.exp) begin n_errors++; $display("FAIL %s: actual %0h required %0h", e.name, int_req, e.exp); end
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    e = sb.pop_front(); n_checks++;
    if (32'(int_req) !== e.exp) begin n_errors++; $display("FAIL %s: actual %0h required %0h", e.name, int_req, e.exp); end
    e = sb.pop_front(); n_checks++;
    if (32'(int_cause) !== e.exp) begin n_errors++; $display("FAIL %s: actual %0h required %0h", e.name, int_cause, e.exp); end
  endtask

  task automatic test_priority();
    exp_t e;
    irq_in[5] = 1'b1;
    irq_in[1] = 1'b1;
    push("prio_first_cause", 32'd17);
    push("prio_second_cause", 32'd21);
    push("prio_done_req", 32'd0);
    tick();
    irq_in = '0;
    repeat (LAT - 1) tick();
    e = sb.pop_front(); n_checks++;
    if (32'(int_cause) !== e.exp) begin n_errors++; $display("FAIL %s: actual %0h required %0h", e.name, int_cause, e.exp); end
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    e = sb.pop_front(); n_checks++;
    if (32'(int_cause) !== e.exp) begin n_errors++; $display("FAIL %s: actual %0h required %0h", e.name, int_cause, e.exp); end
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    e = sb.pop_front(); n_checks++;
    if (32'(int_req) !== e.exp) begin n_errors++; $display("FAIL %s: actual %0h required %0h", e.name, int_req, e.exp); end
  endtask

  task automatic test_level();
    exp_t e;
    csr_data_t rd;
    csr_write(csr_addr_mirqmode, 32'h3FE);
    irq_in[0] = 1'b1;
    push("lvl_req", 32'd1);
    push("lvl_cause", 32'd16);
    push("lvl_after_ack", 32'd1);
    repeat (LAT) tick();
    e = sb.pop_front(); n_checks++;
    if (32'(int_req) !== e.exp) begin n_errors++; $display("FAIL %s: actual %0h required %0h", e.name, int_req, e.exp); end
    e = sb.pop_front(); n_checks++;
    if (32'(int_cause) !== e.exp) begin n_errors++; $display("FAIL %s: actual %0h required %0h", e.name, int_cause, e.exp); end
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    e = sb.pop_front(); n_checks++;
    if (32'(int_req) !== e.exp) begin n_errors++; $display("FAIL %s: actual %0h required %0h", e.name, int_req, e.exp); end
    irq_in[0] = 1'b0;
    push("lvl_drop_early", 32'd1);
    push("lvl_drop_req", 32'd0);
    repeat (LAT - 1) tick();
    e = sb.pop_front(); n_checks++;
    if (32'(int_req) !== e.exp) begin n_errors++; $display("FAIL %s: actual %0h required %0h", e.name, int_req, e.exp); end
    tick();
    e = sb.pop_front(); n_checks++;
    if (32'(int_req) !== e.exp) begin n_errors++; $display("FAIL %s: actual %0h required %0h", e.name, int_req, e.exp); end
    // level-to-edge switch while the line is high
    irq_in[0] = 1'b1;
    push("l2e_pre_req", 32'd1);
    push("l2e_cleared", 32'd0);
    push("l2e_no_spurious", 32'd0);
    push("l2e_mip", 32'h0);
    repeat (LAT) tick();
    e = sb.pop_front(); n_checks++;
    if (32'(int_req) !== e.exp) begin n_errors++; $display("FAIL %s: actual %0h required %0h", e.name, int_req, e.exp); end
    csr_write(csr_addr_mirqmode, 32'h3FF);
    e = sb.pop_front(); n_checks++;
    if (32'(int_req) !== e.exp) begin n_errors++; $display("FAIL %s: actual %0h required %0h", e.name, int_req, e.exp); end
    repeat (4) tick();
    e = sb.pop_front(); n_checks++;
    if (32'(int_req) !== e.exp) begin n_errors++; $display("FAIL %s: actual %0h required %0h", e.name, int_req, e.exp); end
    csr_read(csr_addr_mip, rd);
    e = sb.pop_front(); n_checks++;
    if (rd !== e.exp) begin n_errors++; $display("FAIL %s: actual %0h required %0h", e.name, rd, e.exp); end
    irq_in[0] = 1'b0;
    repeat (LAT + 1) tick();
  endtask

  task automatic test_mip_clear();
    exp_t e;
    csr_data_t rd;
    irq_in[4] = 1'b1;
    push("mip_set", 32'h0010_0000);
    push("mip_write_ones", 32'h0010_0000);
    push("mip_write_zero", 32'h0);
    repeat (LAT) tick();
    irq_in[4] = 1'b0;
    csr_read(csr_addr_mip, rd);
    e = sb.pop_front(); n_checks++;
    if (rd !== e.exp) begin n_errors++; $display("FAIL %s: actual %0h required %0h", e.name, rd, e.exp); end
    csr_write(csr_addr_mip, 32'hFFFF_FFFF);
    csr_read(csr_addr_mip, rd);
    e = sb.pop_front(); n_checks++;
    if (rd !== e.exp) begin n_errors++; $display("FAIL %s: actual %0h required %0h", e.name, rd, e.exp); end
    csr_write(csr_addr_mip, 32'hFFEF_FFFF);
    csr_read(csr_addr_mip, rd);
    e = sb.pop_front(); n_checks++;
    if (rd !== e.exp) begin n_errors++; $display("FAIL %s: actual %0h required %0h", e.name, rd, e.exp); end
    // new edge on channel 3 lands on the same edge as a mip=0 write
    irq_in[3] = 1'b1;
    push("race_pre_mip", 32'h0);
    push("race_mip", 32'h0008_0000);
    push("race_cleared", 32'h0);
    repeat (LAT - 1) tick();
    csr_read(csr_addr_mip, rd);
    e = sb.pop_front(); n_checks++;
    if (rd !== e.exp) begin n_errors++; $display("FAIL %s: actual %0h required %0h", e.name, rd, e.exp); end
    csr_write(csr_addr_mip, 32'h0);
    csr_read(csr_addr_mip, rd);
    e = sb.pop_front(); n_checks++;
    if (rd !== e.exp) begin n_errors++; $display("FAIL %s: actual %0h required %0h", e.name, rd, e.exp); end
    irq_in[3] = 1'b0;
    csr_write(csr_addr_mip, 32'h0);
    csr_read(csr_addr_mip, rd);
    e = sb.pop_front(); n_checks++;
    if (rd !== e.exp) begin n_errors++; $display("FAIL %s: actual %0h required %0h", e.name, rd, e.exp); end
  endtask

  task automatic test_global_mie();
    exp_t e;
    csr_data_t rd;
    irq_in[7] = 1'b1;
    push("gmie_off_req", 32'd0);
    push("gmie_off_cause", 32'd0);
    push("gmie_retained", 32'h0080_0000);
    push("gmie_on_req", 32'd1);
    push("gmie_on_cause", 32'd23);
    push("mie_masked_req", 32'd0);
    push("mie_unmasked_req", 32'd1);
    push("gmie_ack_req", 32'd0);
    repeat (LAT) tick();
    irq_in[7] = 1'b0;
    global_mie = 1'b0;
    #1;
    e = sb.pop_front(); n_checks++;
    if (32'(int_req) !== e.exp) begin n_errors++; $display("FAIL %s: actual %0h required %0h", e.name, int_req, e.exp); end
    e = sb.pop_front(); n_checks++;
    if (32'(int_cause) !== e.exp) begin n_errors++; $display("FAIL %s: actual %0h required %0h", e.name, int_cause, e.exp); end
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    csr_read(csr_addr_mip, rd);
    e = sb.pop_front(); n_checks++;
    if (rd !== e.exp) begin n_errors++; $display("FAIL %s: actual %0h required %0h", e.name, rd, e.exp); end
    global_mie = 1'b1;
    #1;
    e = sb.pop_front(); n_checks++;
    if (32'(int_req) !== e.exp) begin n_errors++; $display("FAIL %s: actual %0h required %0h", e.name, int_req, e.exp); end
    e = sb.pop_front(); n_checks++;
    if (32'(int_cause) !== e.exp) begin n_errors++; $display("FAIL %s: actual %0h required %0h", e.name, int_cause, e.exp); end
    csr_write(csr_addr_mie, 32'h037F_0000);
    e = sb.pop_front(); n_checks++;
    if (32'(int_req) !== e.exp) begin n_errors++; $display("FAIL %s: actual %0h required %0h", e.name, int_req, e.exp); end
    csr_write(csr_addr_mie, 32'h03FF_0000);
    e = sb.pop_front(); n_checks++;
    if (32'(int_req) !== e.exp) begin n_errors++; $display("FAIL %s: actual %0h required %0h", e.name, int_req, e.exp); end
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    e = sb.pop_front(); n_checks++;
    if (32'(int_req) !== e.exp) begin n_errors++; $display("FAIL %s: actual %0h required %0h", e.name, int_req, e.exp); end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    csr_data_t rd;
    csr_write(csr_addr_mirqmode, 32'h0F0);
    irq_in[6] = 1'b1;
    push("mid_pre_req", 32'd1);
    push("mid_rst_req", 32'd0);
    push("mid_rst_cause", 32'd0);
    push("mid_post_mip", 32'h0);
    push("mid_post_mie", 32'h0);
    push("mid_post_mode", 32'h3FF);
    push("mid_post_req", 32'd0);
    push("mid_new_cause", 32'd22);
    repeat (LAT) tick();
    irq_in[6] = 1'b0;
    e = sb.pop_front(); n_checks++;
    if (32'(int_req) !== e.exp) begin n_errors++; $display("FAIL %s: actual %0h required %0h", e.name, int_req, e.exp); end
    #2;
    rst_n = 1'b0;
    #1;
    e = sb.pop_front(); n_checks++;
    if (32'(int_req) !== e.exp) begin n_errors++; $display("FAIL %s: actual %0h required %0h", e.name, int_req, e.exp); end
    e = sb.pop_front(); n_checks++;
    if (32'(int_cause) !== e.exp) begin n_errors++; $display("FAIL %s: actual %0h required %0h", e.name, int_cause, e.exp); end
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    csr_read(csr_addr_mip, rd);
    e = sb.pop_front(); n_checks++;
    if (rd !== e.exp) begin n_errors++; $display("FAIL %s: actual %0h required %0h", e.name, rd, e.exp); end
    csr_read(csr_addr_mie, rd);
    e = sb.pop_front(); n_checks++;
    if (rd !== e.exp) begin n_errors++; $display("FAIL %s: actual %0h required %0h", e.name, rd, e.exp); end
    csr_read(csr_addr_mirqmode, rd);
    e = sb.pop_front(); n_checks++;
    if (rd !== e.exp) begin n_errors++; $display("FAIL %s: actual %0h required %0h", e.name, rd, e.exp); end
    csr_write(csr_addr_mie, 32'h03FF_0000);
    repeat (LAT + 1) tick();
    e = sb.pop_front(); n_checks++;
    if (32'(int_req) !== e.exp) begin n_errors++; $display("FAIL %s: actual %0h required %0h", e.name, int_req, e.exp); end
    irq_in[6] = 1'b1;
    tick();
    irq_in[6] = 1'b0;
    repeat (LAT - 1) tick();
    e = sb.pop_front(); n_checks++;
    if (32'(int_cause) !== e.exp) begin n_errors++; $display("FAIL %s: actual %0h required %0h", e.name, int_cause, e.exp); end
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
  endtask

  initial begin
    bus.csr_rd_en   = 1'b0;
    bus.csr_wr_en   = 1'b0;
    bus.csr_addr    = '0;
    bus.csr_wr_data = '0;
    test_reset();
    test_edge();
    test_priority();
    test_level();
    test_mip_clear();
    test_global_mie();
    test_reset_mid();
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: actual %0d entries left, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach its end, required completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 SHALL have parameter NUM_IRQ, default 10: number of external interrupt channels, legal range 1..16.
REQ-002 SHALL have parameter FIRST_CAUSE, default 16: mcause code of channel 0; FIRST_CAUSE+NUM_IRQ SHALL be at most 32, else elaboration error.
REQ-003 SHALL have parameter EDGE_DEFAULT, default all-ones [NUM_IRQ-1:0]: reset value of the per-channel mode register (1 = edge, 0 = level).
REQ-004 SHALL use one clock, clk; reset rst_n is asynchronous and active-low.
REQ-005 Ports: clk in 1 clock; rst_n in 1 async active-low reset.
REQ-006 Ports: irq_in in NUM_IRQ raw interrupt lines; global_mie in 1 mstatus.MIE.
REQ-007 Ports: csr_rd_en in 1; csr_wr_en in 1; csr_addr in 12; csr_wr_data in 32; csr_rd_data out 32.
REQ-008 Ports: int_req out 1 interrupt request; int_cause out 5 cause code; int_ack in 1 single-cycle trap-taken pulse.

Function
REQ-009 SHALL implement mip (0x344) and mie (0x304) bits [FIRST_CAUSE+NUM_IRQ-1:FIRST_CAUSE] plus custom mirqmode (0x7C0) bits [NUM_IRQ-1:0]; all other bits read 0, and writes to them are ignored.
REQ-010 csr_rd_data SHALL be combinational: the selected register when csr_rd_en=1 and the address matches, else 0.
REQ-011 Edge channel: a rising edge (synced=1, prev=0) SHALL set pending on the next clk edge; pending SHALL hold until cleared.
REQ-012 Level channel: pending SHALL equal the synced level each cycle; CSR writes and int_ack SHALL not affect it.
REQ-013 A CSR write to mip SHALL clear edge pending bits written 0; bits written 1 SHALL be ignored, so software cannot set pending.
REQ-014 int_req SHALL be combinational: global_mie AND OR(pending AND mie).
REQ-015 int_cause SHALL be FIRST_CAUSE plus the lowest enabled pending index, and SHALL be 0 when int_req=0.
REQ-016 int_ack SHALL clear the pending bit of the channel indicated by the current int_cause on the same clk edge; int_ack with int_req=0 SHALL have no effect.
REQ-017 A simultaneous new edge and a clear (ack or CSR) on the same channel SHALL leave pending set.
REQ-018 A mode change edge-to-level SHALL take effect next cycle; a change level-to-edge SHALL clear pending and load prev with the current synced value, so no spurious edge is seen.
REQ-019 Latency, input rise to pending visible: 3 cycles with sync, 1 cycle without.

Reset
REQ-020 Asynchronous assertion SHALL force: pending=0, mie=0, mirqmode=EDGE_DEFAULT, sync and prev flops=0; int_req=0, int_cause=0, csr_rd_data=0.
REQ-021 Reset asserted mid-operation SHALL discard all pending interrupts; the first edge detection after release SHALL need a 0->1 transition.

Configuration
REQ-022 Macro IRQ_CTRL_SYNC_EN defined: each irq_in SHALL pass through a 2-flop synchronizer before edge and level detection.
REQ-023 Macro IRQ_CTRL_SYNC_EN undefined: irq_in SHALL be used directly, for sources already in the clk domain.

Structure
REQ-024 CSR addresses (including csr_addr_mirqmode) and the constant IRQ_FIRST_CAUSE SHALL live in package saratoga; the rv32 CSR types SHALL be reused.
REQ-025 The lowest-index-first priority encoder SHALL be sub-module irq_prio_enc, parameterised by width, with outputs valid and index.

Verification
REQ-026 Scenario: channel 2 edge, mie bit 18 set, global_mie=1, irq_in[2] 0->1 -> int_req=1 and int_cause=18 after 3 cycles (sync on); int_ack -> int_req=0 on the next cycle.
REQ-027 Scenario: channels 5 and 1 pending and enabled -> int_cause=17; ack -> int_cause=21 on the next cycle.
REQ-028 Scenario: channel 0 level mode, irq_in[0] held at 1, int_ack pulsed -> int_req stays 1; irq_in drops -> int_req=0 after the sync latency.
REQ-029 Scenario: write mip=0 in the same cycle as a new edge on channel 3 -> mip bit 19 reads 1.
REQ-030 Scenario: pending bits set, rst_n asserted asynchronously mid-cycle -> int_req=0 immediately; after release, mip reads 0 and mirqmode reads EDGE_DEFAULT.
REQ-031 Scenario: global_mie=0 with enabled pending -> int_req=0 and the pending bit is retained; global_mie=1 -> int_req=1 in the same cycle.
